// File: rtl/path_delay_ctrl_pkg.sv
// Shared types and defaults for the path-delay measurement controller.
package path_delay_pkg;

  localparam int unsigned DefaultCntW    = 16;
  localparam int unsigned DefaultTrialW  = 8;
  localparam int unsigned DefaultMaxWait = 1000;

  localparam logic [1:0] MODE_RISE = 2'd0;
  localparam logic [1:0] MODE_FALL = 2'd1;
  localparam logic [1:0] MODE_ALT  = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StPreset,
    StWait,
    StCapture,
    StDone
  } state_e;

  // Level the path is parked at before launch; reserved mode behaves as rising.
  function automatic logic init_level(logic [1:0] mode, logic trial_odd);
    case (mode)
      MODE_FALL: init_level = 1'b1;
      MODE_ALT:  init_level = trial_odd;
      default:   init_level = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/path_delay_ctrl_if.sv
// Host handshake, path-under-test and result signals of path_delay_ctrl.
interface path_delay_ctrl_if import path_delay_pkg::*; #(
  parameter int unsigned CNT_W   = DefaultCntW,
  parameter int unsigned TRIAL_W = DefaultTrialW,
  parameter int unsigned SUM_W   = CNT_W + TRIAL_W
);
  logic               start;
  logic [1:0]         mode;
  logic [TRIAL_W-1:0] num_trials;
  logic               path_result;
  logic               path_input;
  logic               ld_reg;
  logic               busy;
  logic               done;
  logic               timeout;
  logic [TRIAL_W-1:0] trial_idx;
  logic [CNT_W-1:0]   last_count;
  logic [SUM_W-1:0]   sum_count;
  logic [CNT_W-1:0]   min_count;
  logic [CNT_W-1:0]   max_count;

  modport master (
    output start, mode, num_trials, path_result,
    input  path_input, ld_reg, busy, done, timeout, trial_idx, last_count, sum_count,
    input  min_count, max_count
  );

  modport slave (
    input  start, mode, num_trials, path_result,
    output path_input, ld_reg, busy, done, timeout, trial_idx, last_count, sum_count,
    output min_count, max_count
  );
endinterface

// File: rtl/path_delay_ctrl_counter.sv
// Clear/enable counter with a flag on the last cycle before MaxCount is reached.
module path_delay_counter #(
  parameter int unsigned Width    = 16,
  parameter int unsigned MaxCount = 1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic             last_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  // High when one more increment would reach MaxCount.
  assign last_o = (cnt_q == Width'(MaxCount - 1));

endmodule

// File: rtl/path_delay_ctrl.sv
// Multi-trial path-delay controller: launches edges into a path and counts cycles to arrival.
// Define PATH_DELAY_MINMAX_EN to track min/max trial counts.
module path_delay_ctrl import path_delay_pkg::*; #(
  parameter int unsigned CNT_W    = DefaultCntW,
  parameter int unsigned TRIAL_W  = DefaultTrialW,
  parameter int unsigned MAX_WAIT = DefaultMaxWait,
  parameter int unsigned SUM_W    = CNT_W + TRIAL_W
) (
  input logic              clk,
  input logic              rst,
  path_delay_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [TRIAL_W-1:0] last_idx_q, last_idx_d;
  logic [TRIAL_W-1:0] trial_q, trial_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               timeout_q, timeout_d;

  logic               cnt_clr, cnt_en, cnt_last;
  logic [CNT_W-1:0]   cnt;
  logic               init_lvl, tgt_lvl;

  assign init_lvl = init_level(mode_q, trial_q[0]);
  assign tgt_lvl  = ~init_lvl;

  path_delay_counter #(
    .Width    (CNT_W),
    .MaxCount (MAX_WAIT)
  ) u_wait_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    last_idx_d     = last_idx_q;
    trial_d        = trial_q;
    last_d         = last_q;
    sum_d          = sum_q;
    timeout_d      = timeout_q;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    bus.path_input = 1'b0;
    bus.ld_reg     = 1'b0;
    bus.done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d     = bus.mode;
          // Zero trials runs once, so store the index of the final trial.
          last_idx_d = (bus.num_trials == '0) ? '0 : bus.num_trials - 1'b1;
          sum_d      = '0;
          trial_d    = '0;
          timeout_d  = 1'b0;
          cnt_clr    = 1'b1;
          state_d    = StPreset;
        end
      end
      StPreset: begin
        bus.path_input = init_lvl;
        if (bus.path_result == init_lvl) begin
          cnt_clr = 1'b1;
          state_d = StWait;
        end else if (cnt_last) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StWait: begin
        bus.path_input = tgt_lvl;
        if (bus.path_result == tgt_lvl) begin
          state_d = StCapture;
        end else if (cnt_last) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StCapture: begin
        bus.path_input = tgt_lvl;
        bus.ld_reg     = 1'b1;
        last_d         = cnt;
        sum_d          = sum_q + SUM_W'(cnt);
        if (trial_q == last_idx_q) begin
          state_d = StDone;
        end else begin
          trial_d = trial_q + 1'b1;
          cnt_clr = 1'b1;
          state_d = StPreset;
        end
      end
      StDone: begin
        bus.done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= MODE_RISE;
      last_idx_q <= '0;
      trial_q    <= '0;
      last_q     <= '0;
      sum_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      last_idx_q <= last_idx_d;
      trial_q    <= trial_d;
      last_q     <= last_d;
      sum_q      <= sum_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.timeout    = timeout_q;
  assign bus.trial_idx  = trial_q;
  assign bus.last_count = last_q;
  assign bus.sum_count  = sum_q;

`ifdef PATH_DELAY_MINMAX_EN
  logic             run_start, capture;
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;

  assign run_start = (state_q == StIdle) && bus.start;
  assign capture   = (state_q == StCapture);

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (run_start) begin
      min_d = '1;
      max_d = '0;
    end else if (capture) begin
      if (cnt < min_q) min_d = cnt;
      if (cnt > max_q) max_d = cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign bus.min_count = min_q;
  assign bus.max_count = max_q;
`else
  assign bus.min_count = '0;
  assign bus.max_count = '0;
`endif

endmodule

// File: tb/tb_path_delay_ctrl.sv
// Directed bench for path_delay_ctrl with an asymmetric-delay path model.
module tb_path_delay_ctrl;
  import path_delay_pkg::*;

  localparam int unsigned CntW   = 16;
  localparam int unsigned TrialW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  path_delay_ctrl_if #(.CNT_W(CntW), .TRIAL_W(TrialW)) bus ();

  path_delay_ctrl #(.CNT_W(CntW), .TRIAL_W(TrialW), .MAX_WAIT(1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Path model: output follows path_input after rise_d / fall_d cycles.
  int   rise_d = 5;
  int   fall_d = 7;
  bit   stuck = 1'b0;
  bit   use_tab = 1'b0;
  int   rise_tab[3];
  int   rise_n = 0;
  int   tab_base = 0;
  int   tab_i;
  int   d_now;
  int   age = 0;
  logic pr_q = 1'b0;

  always_comb begin
    tab_i = rise_n - tab_base;
    if (tab_i > 2) tab_i = 2;
    if (tab_i < 0) tab_i = 0;
    d_now = bus.path_input ? (use_tab ? rise_tab[tab_i] : rise_d) : fall_d;
    bus.path_result = stuck ? 1'b0 : ((d_now == 0) ? bus.path_input : pr_q);
  end

  always @(posedge clk) begin
    if (bus.path_input != pr_q) begin
      if (d_now == 0 || age >= d_now - 1) begin
        pr_q <= bus.path_input;
        age  <= 0;
        if (bus.path_input) rise_n <= rise_n + 1;
      end else begin
        age <= age + 1;
      end
    end else begin
      age <= 0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_path_input"}, bus.path_input, 0);
    chk({tag, "_ld_reg"}, bus.ld_reg, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_timeout"}, bus.timeout, 0);
    chk({tag, "_trial_idx"}, bus.trial_idx, 0);
    chk({tag, "_last_count"}, bus.last_count, 0);
    chk({tag, "_sum_count"}, bus.sum_count, 0);
`ifdef PATH_DELAY_MINMAX_EN
    chk({tag, "_min_count"}, bus.min_count, 16'hFFFF);
`else
    chk({tag, "_min_count"}, bus.min_count, 0);
`endif
    chk({tag, "_max_count"}, bus.max_count, 0);
  endtask

  // Starts one run, scrambles mode/num_trials afterwards, optionally re-pulses
  // start at loop iteration extra_start, and watches until done.
  task automatic do_run(input logic [1:0] m, input logic [7:0] n, input int extra_start,
                        output int lds, output int dones, output int cyc,
                        output bit ld_before_done, output bit busy_after);
    bit prev_ld;
    bit finished;
    lds = 0; dones = 0; cyc = -1; ld_before_done = 1'b0; prev_ld = 1'b0; finished = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.num_trials = n;
    @(negedge clk);
    bus.start = 1'b0; bus.mode = ~m; bus.num_trials = n + 8'd5;
    for (int k = 0; k < 5000 && !finished; k++) begin
      bus.start = (k == extra_start);
      if (bus.ld_reg) lds++;
      if (bus.done) begin
        dones++; cyc = k; ld_before_done = prev_ld; finished = 1'b1;
      end
      prev_ld = bus.ld_reg;
      if (!finished) @(negedge clk);
    end
    bus.start = 1'b0;
    chk("run_done_within_bound", finished, 1);
    @(negedge clk);
    if (bus.done) dones++;
    busy_after = bus.busy;
  endtask

  task automatic settle();
    repeat (60) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] n;
    int         rise;
    int         fall;
    int         last;
    int         sum;
    int         idx;
    int         lds;
  } vec_t;

  vec_t vecs[5];

  int lds, dones, cyc, busy_cnt;
  bit ldb, busy_after;

  initial begin
    vecs[0] = '{2'd0, 8'd1, 5, 7, 5, 5, 0, 1};   // single rising trial
    vecs[1] = '{2'd2, 8'd4, 3, 7, 7, 20, 3, 4};  // alternate 3/7
    vecs[2] = '{2'd3, 8'd0, 3, 7, 3, 3, 0, 1};   // reserved mode, zero trials
    vecs[3] = '{2'd1, 8'd2, 2, 6, 6, 12, 1, 2};  // falling
    vecs[4] = '{2'd0, 8'd3, 0, 2, 0, 0, 2, 3};   // zero-latency path
    rise_tab[0] = 4; rise_tab[1] = 9; rise_tab[2] = 2;

    rst = 1'b1; bus.start = 1'b0; bus.mode = 2'd0; bus.num_trials = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      rise_d = vecs[i].rise; fall_d = vecs[i].fall;
      do_run(vecs[i].mode, vecs[i].n, -1, lds, dones, cyc, ldb, busy_after);
      chk($sformatf("row%0d_last_count", i), bus.last_count, vecs[i].last);
      chk($sformatf("row%0d_sum_count", i), bus.sum_count, vecs[i].sum);
      chk($sformatf("row%0d_trial_idx", i), bus.trial_idx, vecs[i].idx);
      chk($sformatf("row%0d_ld_pulses", i), lds, vecs[i].lds);
      chk($sformatf("row%0d_done_pulses", i), dones, 1);
      chk($sformatf("row%0d_timeout", i), bus.timeout, 0);
      chk($sformatf("row%0d_done_after_capture", i), ldb, 1);
      chk($sformatf("row%0d_idle_after_done", i), busy_after, 0);
      if (i == 0) chk("row0_done_cycle", cyc, 8);
      settle();
    end

    // start pulsed mid-run must not restart the run
    rise_d = 20; fall_d = 7;
    do_run(2'd0, 8'd1, 4, lds, dones, cyc, ldb, busy_after);
    chk("busy_start_last_count", bus.last_count, 20);
    chk("busy_start_ld_pulses", lds, 1);
    chk("busy_start_trial_idx", bus.trial_idx, 0);
    chk("busy_start_done_pulses", dones, 1);
    settle();

    // rising trials with delays 4, 9, 2
    fall_d = 3; tab_base = rise_n; use_tab = 1'b1;
    do_run(2'd0, 8'd3, -1, lds, dones, cyc, ldb, busy_after);
    chk("minmax_last_count", bus.last_count, 2);
    chk("minmax_sum_count", bus.sum_count, 15);
    chk("minmax_ld_pulses", lds, 3);
`ifdef PATH_DELAY_MINMAX_EN
    chk("minmax_min_count", bus.min_count, 2);
    chk("minmax_max_count", bus.max_count, 9);
`else
    chk("minmax_min_count", bus.min_count, 0);
    chk("minmax_max_count", bus.max_count, 0);
`endif
    settle();
    use_tab = 1'b0;

    // path stuck low: 1000 WAIT cycles then timeout
    stuck = 1'b1;
    do_run(2'd0, 8'd1, -1, lds, dones, cyc, ldb, busy_after);
    chk("timeout_flag", bus.timeout, 1);
    chk("timeout_ld_pulses", lds, 0);
    chk("timeout_done_pulses", dones, 1);
    chk("timeout_done_cycle", cyc, 1001);
    chk("timeout_last_count_kept", bus.last_count, 2);
    chk("timeout_sum_count", bus.sum_count, 0);
    repeat (5) @(negedge clk);
    chk("timeout_held_in_idle", bus.timeout, 1);
    stuck = 1'b0;
    settle();

    // reset mid-WAIT
    rise_d = 20;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd0; bus.num_trials = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrun_busy", bus.busy, 1);
    chk("midrun_path_input", bus.path_input, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midrun_reset");
    rst = 1'b0;
    dones = 0; busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.busy) busy_cnt++;
    end
    chk("post_reset_no_done", dones, 0);
    chk("post_reset_idle", busy_cnt, 0);

    rise_d = 5; fall_d = 7;
    do_run(2'd0, 8'd1, -1, lds, dones, cyc, ldb, busy_after);
    chk("fresh_last_count", bus.last_count, 5);
    chk("fresh_sum_count", bus.sum_count, 5);
    chk("fresh_ld_pulses", lds, 1);
    chk("fresh_timeout", bus.timeout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/path_delay_ctrl.md
Name: path_delay_ctrl

Overview:
- Parametrised successor to the single-shot low-to-high path-delay controller.
- Drives the launch input of a delay path under test and counts clock cycles until the path output reaches the launched level.
- Repeats for N trials in rising, falling or alternating mode and accumulates the results.
- Sits between the host or measurement sequencer (start/done handshake) and the path-under-test plus its capture register (ld_reg).

Parameters:
- CNT_W, 16, width of the per-trial cycle counter and last_count.
- TRIAL_W, 8, width of num_trials and trial_idx.
- MAX_WAIT, 1000, cycles allowed in PRESET or WAIT before declaring timeout; must be < 2**CNT_W.
- SUM_W, CNT_W+TRIAL_W, accumulator width; derived value, never overflows.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- mode  in  2  0=rising, 1=falling, 2=alternate (trial 0 rising), 3=reserved, treated as 0; latched at start.
- num_trials  in  TRIAL_W  trials per run; 0 treated as 1; latched at start.
- path_result  in  1  output of path under test, already synchronised.
- path_input  out  1  launch drive into path under test.
- ld_reg  out  1  one-cycle capture strobe to external result register.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at run end.
- timeout  out  1  run ended on timeout; held until next start.
- trial_idx  out  TRIAL_W  index of current or last trial.
- last_count  out  CNT_W  cycle count of last completed trial.
- sum_count  out  SUM_W  sum of counts of completed trials.
- min_count, max_count  out  CNT_W  optional; see feature.

Behaviour:
- Reset (synchronous): state=IDLE; path_input, ld_reg, busy, done and timeout=0; all counts and trial_idx=0.
- Per-trial levels:
  - init level = 0 for a rising trial, 1 for a falling trial.
  - Target level = ~init.
  - Alternate mode: even trial_idx is rising, odd is falling.
- IDLE:
  - path_input=0.
  - On start=1: latch mode and num_trials; clear sum_count, trial_idx and timeout; go to PRESET next cycle.
- PRESET:
  - path_input=init.
  - Wait counter cleared on entry, increments each cycle.
  - If path_result==init: go to WAIT next cycle.
  - If counter reaches MAX_WAIT first: set timeout=1 and go to DONE.
- WAIT:
  - path_input=target; cnt=0 on first WAIT cycle.
  - Each cycle with path_result!=target: cnt++.
  - Cycle with path_result==target: go to CAPTURE, holding cnt.
  - If cnt reaches MAX_WAIT without a match: set timeout=1, go to DONE, leave last_count unchanged, add nothing to sum_count.
- CAPTURE (1 cycle):
  - ld_reg=1; path_input stays at target.
  - last_count<=cnt; sum_count<=sum_count+cnt.
  - If trial_idx==num_trials-1: go to DONE.
  - Otherwise trial_idx++ and go to PRESET.
- DONE (1 cycle): done=1, busy=1, path_input=0; then IDLE.
- Latency: a path that is already at target on the first WAIT cycle gives count 0.
- Ignored inputs:
  - start while busy is ignored; no queuing.
  - Changes to mode and num_trials during a run are ignored.
- Outputs last_count, sum_count, trial_idx and timeout hold their values in IDLE until the next start.
- Reset asserted mid-run: immediate return to reset values on the next edge; no done or ld_reg pulse.
- Sum width: SUM_W covers (2**TRIAL_W)*(2**CNT_W-1), so there is no wrap and no saturation logic.

Optional Feature:
- Macro PATH_DELAY_MINMAX_EN.
- Defined:
  - min_count and max_count are updated in CAPTURE with the running min/max of cnt.
  - Reset and start set min_count to all ones and max_count to 0.
- Undefined: min_count and max_count are tied to 0 and no tracking registers exist. The port list is identical in both builds.

Decomposition:
- Shared package path_delay_pkg holds:
  - state enum (IDLE, PRESET, WAIT, CAPTURE, DONE);
  - mode encodings (MODE_RISE=0, MODE_FALL=1, MODE_ALT=2);
  - default CNT_W, TRIAL_W and MAX_WAIT.
- One natural sub-module: path_delay_counter, the clear/enable/terminal-count counter reused for both the PRESET and WAIT timeouts. The FSM stays in the top module.

Test Plan:
- Rising, 1 trial: model raises path_result 5 cycles after path_input rises. Expect last_count=5, sum_count=5, one ld_reg pulse, done one cycle after CAPTURE, timeout=0.
- Alternate, num_trials=4: model delays 3 cycles rising and 7 cycles falling. Expect path_input pattern 0→1, 1→0, 0→1, 1→0, four ld_reg pulses, sum_count=20, trial_idx=3, last_count=7.
- Timeout: path_result stuck at 0 in rising mode with MAX_WAIT=1000. Expect timeout=1 after 1000 WAIT cycles, no ld_reg, last_count unchanged, done pulse.
- num_trials=0 and mode=3: expect exactly one rising trial.
- Simultaneous events: start pulsed while busy, then rst asserted mid-WAIT. Expect the second start ignored; after rst all outputs are at reset values with no done pulse, and a fresh start runs normally.
- With PATH_DELAY_MINMAX_EN, 3 trials of delays 4, 9, 2: expect min_count=2, max_count=9. Without the macro both read 0.
